// File: rtl/cave_cache_ctrl.sv
// rtl/cave_cache_ctrl.sv - write-back, write-allocate controller for a 4-entry direct-mapped line cache
//
// Sequences lookup, eviction, fill and entry update against an external entry memory.
// The entry memory has a 1-cycle registered-address read port.
// Entry word layout: {valid, dirty, tag, data}, with valid in the MSB.
//
// Ports:
//   clock, reset       system clock, asynchronous active-low reset
//   in_*               requester side: rd/wr/addr/din/mask in; wait/valid/dout out
//   out_*              backing memory: rd/wr/addr/dout out; wait/valid/din in
//   mem_*              entry memory: ren/raddr/rdata read port; wen/waddr/wdata write port
module cave_cache_ctrl #(
    parameter int INDEX_W = 2,
    parameter int TAG_W   = 21,
    parameter int DATA_W  = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_rd,
    input  logic                       in_wr,
    input  logic [TAG_W+INDEX_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]          in_din,
    input  logic [DATA_W/8-1:0]        in_mask,
    output logic                       in_wait,
    output logic                       in_valid,
    output logic [DATA_W-1:0]          in_dout,
    output logic                       out_rd,
    output logic                       out_wr,
    output logic [TAG_W+INDEX_W-1:0]   out_addr,
    output logic [DATA_W-1:0]          out_dout,
    input  logic                       out_wait,
    input  logic                       out_valid,
    input  logic [DATA_W-1:0]          out_din,
    output logic                       mem_ren,
    output logic [INDEX_W-1:0]         mem_raddr,
    input  logic [DATA_W+TAG_W+1:0]    mem_rdata,
    output logic                       mem_wen,
    output logic [INDEX_W-1:0]         mem_waddr,
    output logic [DATA_W+TAG_W+1:0]    mem_wdata
);

    localparam int ADDR_W  = TAG_W + INDEX_W;
    localparam int ENTRY_W = DATA_W + TAG_W + 2;
    localparam int NBYTES  = DATA_W / 8;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_EVICT,
        ST_FILL,
        ST_FILL_WAIT
    } state_t;

    state_t              state_q,       state_d;
    logic [INDEX_W-1:0]  init_cnt_q,    init_cnt_d;
    logic [ADDR_W-1:0]   req_addr_q,    req_addr_d;
    logic [DATA_W-1:0]   req_din_q,     req_din_d;
    logic [NBYTES-1:0]   req_mask_q,    req_mask_d;
    logic                req_wr_q,      req_wr_d;
    logic [TAG_W-1:0]    victim_tag_q,  victim_tag_d;
    logic [DATA_W-1:0]   victim_data_q, victim_data_d;
    logic                in_valid_q,    in_valid_d;
    logic [DATA_W-1:0]   in_dout_q,     in_dout_d;

    logic [INDEX_W-1:0]  req_index;
    logic [TAG_W-1:0]    req_tag;
    logic                ent_valid;
    logic                ent_dirty;
    logic [TAG_W-1:0]    ent_tag;
    logic [DATA_W-1:0]   ent_data;
    logic                hit;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_data,
        input logic [DATA_W-1:0] new_data,
        input logic [NBYTES-1:0] mask
    );
        logic [DATA_W-1:0] r;
        r = old_data;
        for (int b = 0; b < NBYTES; b++) begin
            if (mask[b]) begin
                r[8*b +: 8] = new_data[8*b +: 8];
            end
        end
        return r;
    endfunction

    assign req_index = req_addr_q[INDEX_W-1:0];
    assign req_tag   = req_addr_q[ADDR_W-1:INDEX_W];
    assign ent_valid = mem_rdata[ENTRY_W-1];
    assign ent_dirty = mem_rdata[ENTRY_W-2];
    assign ent_tag   = mem_rdata[DATA_W +: TAG_W];
    assign ent_data  = mem_rdata[DATA_W-1:0];
    assign hit       = ent_valid && (ent_tag == req_tag);

    assign in_valid = in_valid_q;
    assign in_dout  = in_dout_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            req_addr_q    <= '0;
            req_din_q     <= '0;
            req_mask_q    <= '0;
            req_wr_q      <= 1'b0;
            victim_tag_q  <= '0;
            victim_data_q <= '0;
            in_valid_q    <= 1'b0;
            in_dout_q     <= '0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            req_addr_q    <= req_addr_d;
            req_din_q     <= req_din_d;
            req_mask_q    <= req_mask_d;
            req_wr_q      <= req_wr_d;
            victim_tag_q  <= victim_tag_d;
            victim_data_q <= victim_data_d;
            in_valid_q    <= in_valid_d;
            in_dout_q     <= in_dout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        req_addr_d    = req_addr_q;
        req_din_d     = req_din_q;
        req_mask_d    = req_mask_q;
        req_wr_d      = req_wr_q;
        victim_tag_d  = victim_tag_q;
        victim_data_d = victim_data_q;
        in_valid_d    = 1'b0;
        in_dout_d     = in_dout_q;

        in_wait   = 1'b1;
        out_rd    = 1'b0;
        out_wr    = 1'b0;
        out_addr  = '0;
        out_dout  = '0;
        mem_ren   = 1'b0;
        mem_raddr = '0;
        mem_wen   = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;

        case (state_q)
            ST_INIT: begin
                // Gated by reset so the entry memory sees no writes while reset is held.
                mem_wen    = reset;
                mem_waddr  = init_cnt_q;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == {INDEX_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                in_wait = 1'b0;
                if (in_rd || in_wr) begin
                    req_addr_d = in_addr;
                    req_din_d  = in_din;
                    req_mask_d = in_mask;
                    req_wr_d   = in_wr;
                    mem_ren    = 1'b1;
                    mem_raddr  = in_addr[INDEX_W-1:0];
                    state_d    = ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                if (hit) begin
                    if (req_wr_q) begin
                        mem_wen   = 1'b1;
                        mem_waddr = req_index;
                        mem_wdata = {1'b1, 1'b1, req_tag,
                                     merge_bytes(ent_data, req_din_q, req_mask_q)};
                    end else begin
                        in_valid_d = 1'b1;
                        in_dout_d  = ent_data;
                    end
                    state_d = ST_IDLE;
                end else if (ent_valid && ent_dirty) begin
                    victim_tag_d  = ent_tag;
                    victim_data_d = ent_data;
                    state_d       = ST_EVICT;
                end else begin
                    state_d = ST_FILL;
                end
            end

            ST_EVICT: begin
                out_wr   = 1'b1;
                out_addr = {victim_tag_q, req_index};
                out_dout = victim_data_q;
                if (!out_wait) begin
                    state_d = ST_FILL;
                end
            end

            ST_FILL: begin
                out_rd   = 1'b1;
                out_addr = req_addr_q;
                if (!out_wait) begin
                    state_d = ST_FILL_WAIT;
                end
            end

            ST_FILL_WAIT: begin
                if (out_valid) begin
                    mem_wen   = 1'b1;
                    mem_waddr = req_index;
                    // A write miss allocates the line and merges into it, leaving it dirty.
                    mem_wdata = {1'b1, req_wr_q, req_tag,
                                 req_wr_q ? merge_bytes(out_din, req_din_q, req_mask_q) : out_din};
                    if (!req_wr_q) begin
                        in_valid_d = 1'b1;
                        in_dout_d  = out_din;
                    end
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_cave_cache_ctrl.sv
// tb/tb_cave_cache_ctrl.sv - self-checking bench for cave_cache_ctrl
module tb_cave_cache_ctrl;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         in_rd = 1'b0;
    logic         in_wr = 1'b0;
    logic [22:0]  in_addr = '0;
    logic [63:0]  in_din = '0;
    logic [7:0]   in_mask = '0;
    logic         in_wait;
    logic         in_valid;
    logic [63:0]  in_dout;
    logic         out_rd;
    logic         out_wr;
    logic [22:0]  out_addr;
    logic [63:0]  out_dout;
    logic         out_wait = 1'b0;
    logic         out_valid = 1'b0;
    logic [63:0]  out_din = '0;
    logic         mem_ren;
    logic [1:0]   mem_raddr;
    logic [86:0]  mem_rdata = '0;
    logic         mem_wen;
    logic [1:0]   mem_waddr;
    logic [86:0]  mem_wdata;

    // Entry memory starts with valid garbage tagged 0 so a skipped INIT shows up as false hits.
    logic [86:0]  mem_arr [4] = '{4{ {1'b1, 1'b0, 21'd0, 64'hBAD0BAD0BAD0BAD0} }};

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: cache contents and backing memory as plain arrays.
    bit           ref_valid [4];
    bit           ref_dirty [4];
    logic [20:0]  ref_tag   [4];
    logic [63:0]  ref_data  [4];
    logic [63:0]  backing   [logic [22:0]];

    cave_cache_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .in_rd     (in_rd),
        .in_wr     (in_wr),
        .in_addr   (in_addr),
        .in_din    (in_din),
        .in_mask   (in_mask),
        .in_wait   (in_wait),
        .in_valid  (in_valid),
        .in_dout   (in_dout),
        .out_rd    (out_rd),
        .out_wr    (out_wr),
        .out_addr  (out_addr),
        .out_dout  (out_dout),
        .out_wait  (out_wait),
        .out_valid (out_valid),
        .out_din   (out_din),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_wen) mem_arr[mem_waddr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem_arr[mem_raddr];
    end

    function automatic logic [63:0] back_read(input logic [22:0] a);
        if (backing.exists(a)) return backing[a];
        return {a, 18'h2A5A5, a};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic reset_and_init();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("reset_outputs", {in_wait, in_valid, out_rd, out_wr, mem_wen, mem_ren},
              6'b100000);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (i < 4)
                check("init_write", {mem_wen, mem_waddr, mem_wdata, in_wait},
                      {1'b1, i[1:0], 87'd0, 1'b1});
            else
                check("init_done", {in_wait, mem_wen}, 2'b00);
            @(negedge clock);
        end
        for (int i = 0; i < 4; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
    endtask

    task automatic do_op(input bit wr, input logic [22:0] addr, input logic [63:0] din,
                         input logic [7:0] mask, input int stall);
        logic [1:0]  idx;
        logic [20:0] tag;
        bit          hit, exp_ev, done, fill_acc;
        logic [22:0] ev_addr;
        logic [63:0] ev_data, line, newline, got;
        int          waited, c, ev_seen, ev_bad, fill_seen, fill_bad, fw_cnt, nvalid, vcyc, both;

        idx = addr[1:0];
        tag = addr[22:2];
        hit     = ref_valid[idx] && (ref_tag[idx] == tag);
        exp_ev  = !hit && ref_valid[idx] && ref_dirty[idx];
        ev_addr = {ref_tag[idx], idx};
        ev_data = ref_data[idx];
        if (exp_ev) backing[ev_addr] = ev_data;
        line    = hit ? ref_data[idx] : back_read(addr);
        newline = line;
        if (wr)
            for (int b = 0; b < 8; b++)
                if (mask[b]) newline[8*b +: 8] = din[8*b +: 8];

        waited = 0;
        while (in_wait && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        check("idle_before_op", in_wait, 1'b0);

        in_rd = !wr; in_wr = wr; in_addr = addr; in_din = din; in_mask = mask;
        #1;
        check("accept_lookup", {mem_ren, mem_raddr}, {1'b1, idx});

        done = 0; fill_acc = 0; c = 0; got = '0; vcyc = 0;
        ev_seen = 0; ev_bad = 0; fill_seen = 0; fill_bad = 0; fw_cnt = 0; nvalid = 0; both = 0;
        while (!done && c < 300) begin
            @(negedge clock);
            c++;
            in_rd = 1'b0; in_wr = 1'b0;
            out_valid = 1'b0;
            out_din = {$urandom, $urandom};
            if (in_valid) begin nvalid++; got = in_dout; vcyc = c; end
            if (out_rd && out_wr) both++;
            if (!in_wait) done = 1;
            if (out_wr) begin
                if (out_addr !== ev_addr || out_dout !== ev_data || !in_wait) ev_bad++;
                out_wait = (ev_seen < stall);
                ev_seen++;
            end else if (out_rd) begin
                if (out_addr !== addr || !in_wait) fill_bad++;
                out_wait = (fill_seen < stall);
                fill_seen++;
                if (!out_wait) begin fill_acc = 1; fw_cnt = 0; end
            end else begin
                out_wait = 1'($urandom_range(0, 1));
                if (fill_acc) begin
                    if (fw_cnt == stall) begin
                        out_valid = 1'b1;
                        out_din   = back_read(addr);
                        fill_acc  = 0;
                    end
                    fw_cnt++;
                end
            end
        end
        check("op_timeout", done, 1'b1);
        @(negedge clock);
        if (in_valid) nvalid++;

        check("evict_seen", ev_seen > 0, exp_ev);
        check("evict_held_cycles", ev_seen, exp_ev ? stall + 1 : 0);
        check("evict_addr_data", ev_bad, 0);
        check("fill_seen", fill_seen > 0, !hit);
        check("fill_held_cycles", fill_seen, hit ? 0 : stall + 1);
        check("fill_addr", fill_bad, 0);
        check("rd_wr_exclusive", both, 0);
        check("in_valid_pulses", nvalid, wr ? 0 : 1);
        if (!wr) check("read_data", got, line);
        if (!wr && hit) check("hit_latency", vcyc, 2);

        ref_dirty[idx] = hit ? (ref_dirty[idx] | wr) : wr;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tag;
        ref_data[idx]  = newline;
        check("entry_word", mem_arr[idx], {1'b1, ref_dirty[idx], tag, newline});
    endtask

    initial begin
        int c;

        reset_and_init();

        backing[23'h000001] = 64'h1122334455667788;
        do_op(1'b0, 23'h000001, 64'h0, 8'h00, 0);
        check("cold_fill_entry", mem_arr[1], {1'b1, 1'b0, 21'd0, 64'h1122334455667788});
        do_op(1'b0, 23'h000001, 64'h0, 8'h00, 0);
        do_op(1'b1, 23'h000001, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 0);
        check("write_merge", mem_arr[1][63:0], 64'h11223344FFFFFFFF);
        do_op(1'b0, 23'h000001, 64'h0, 8'h00, 0);
        do_op(1'b0, 23'h000005, 64'h0, 8'h00, 5);
        check("evicted_to_backing", back_read(23'h000001), 64'h11223344FFFFFFFF);

        // Reset while waiting for fill data.
        out_wait = 1'b0;
        in_rd = 1'b1; in_addr = 23'h000009;
        c = 0;
        @(negedge clock);
        in_rd = 1'b0;
        while (!out_rd && c < 20) begin @(negedge clock); c++; end
        check("reach_fill", out_rd, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_outputs", {out_rd, out_wr, in_valid, in_wait, mem_wen}, 5'b00010);
        out_valid = 1'b1;
        out_din = 64'hDEADBEEFDEADBEEF;
        @(negedge clock);
        out_valid = 1'b0;
        reset_and_init();
        do_op(1'b0, 23'h000001, 64'h0, 8'h00, 0);

        for (int n = 0; n < 150; n++) begin
            logic [22:0] a;
            a = {21'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_op(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom),
                  $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cave_cache_ctrl.md
Name: cave_cache_ctrl

Overview:
- Write-back, write-allocate controller for a 4-entry direct-mapped line cache.
- Storage is an external 4x87-bit entry memory: one read port with 1-cycle registered-address latency, and one write port.
- Sits between a single 64-bit requester (CPU/sprite side) and a slower 64-bit backing memory port.
- Sequences lookup, eviction, fill and entry update, and initialises the entry memory after reset.

Parameters:
- INDEX_W, 2, entry index width (4 entries).
- TAG_W, 21, tag width; line address = {tag, index} = 23 bits.
- DATA_W, 64, line data width; entry word = {valid, dirty, tag, data} = 87 bits, valid at bit 86.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_rd  in  1  read request
- in_wr  in  1  write request (priority over in_rd if both high)
- in_addr  in  23  line address {tag, index}
- in_din  in  64  write data
- in_mask  in  8  byte enables for write
- in_wait  out  1  high = request not accepted
- in_valid  out  1  one-cycle read-data strobe
- in_dout  out  64  read data
- out_rd  out  1  backing read request
- out_wr  out  1  backing write request
- out_addr  out  23  backing line address
- out_dout  out  64  backing write data
- out_wait  in  1  backing stall; request held while high
- out_valid  in  1  backing read-data strobe
- out_din  in  64  backing read data
- mem_ren  out  1  entry read enable
- mem_raddr  out  2  entry read address
- mem_rdata  in  87  entry read data, valid the cycle after mem_ren
- mem_wen  out  1  entry write enable
- mem_waddr  out  2  entry write address
- mem_wdata  out  87  entry write data

Behaviour:
- Reset (async assert, sync release): state=INIT, init counter=0.
  - All outputs 0, except in_wait=1.
  - Entry memory is not assumed cleared; INIT clears it.
- INIT: 4 cycles, mem_wen=1, mem_waddr=counter, mem_wdata=0; then IDLE. in_wait=1 throughout.
- IDLE: in_wait=0, combinational from state. Request accepted when (in_rd|in_wr) in IDLE.
  - On accept: latch addr/din/mask/op; mem_ren=1, mem_raddr=index in the same cycle; go LOOKUP.
- LOOKUP (T+1): hit = mem_rdata[86] && tag match.
  - Read hit: register in_dout=data and in_valid=1 for cycle T+2; go IDLE.
  - Write hit: mem_wen at T+1 with {1,1,tag,merged}; go IDLE.
  - Merged data = per-byte in_mask ? in_din : old data.
  - Miss with valid && dirty: latch victim; go EVICT.
  - Miss otherwise: go FILL.
- EVICT: out_wr=1, out_addr={victim tag, index}, out_dout=victim data; held stable until a cycle with out_wait=0, then go FILL.
- FILL: out_rd=1, out_addr=request addr; held until out_wait=0, then go FILL_WAIT.
- FILL_WAIT: wait for out_valid (no timeout).
  - On out_valid: mem_wen with {1, op==wr, tag, op==wr ? merge(out_din) : out_din}.
  - Read: in_valid/in_dout(=out_din) next cycle.
  - Go IDLE.
- in_wait=1 in every state except IDLE; requests outside IDLE are ignored and not queued.
- in_valid pulses exactly one cycle per read; writes produce no in_valid.
- out_rd and out_wr are never high together.
- Write in cycle X to index i followed by accepted read of i at X+1 returns the new data; no bypass is needed.
- Reset mid-operation: abort immediately, drop out_rd/out_wr, no in_valid, restart INIT.

Test Plan:
- Reset release -> 4 mem_wen cycles, addr 0..3, wdata 0; in_wait falls on cycle 5.
- Read 0x000001 (index 1, cold) -> out_rd addr 0x000001; out_valid with 0x1122334455667788 -> entry 1 written {1,0,tag 0}; in_valid with that data. Repeat read -> hit, in_valid at accept+2, no out_rd.
- Write 0x000001, din 0xFFFF...FF, mask 0x0F -> entry data 0x11223344FFFFFFFF, dirty=1; following read returns it.
- Read 0x000005 (same index 1, new tag 1) -> out_wr addr 0x000001 data 0x11223344FFFFFFFF first, then out_rd 0x000005.
- Hold out_wait=1 for 5 cycles during EVICT and FILL -> out_addr/out_dout stable, in_wait=1, no state advance.
- Assert reset in FILL_WAIT -> out_rd=0 at once, no in_valid, INIT re-runs, all entries invalid (next read misses).
